// File: rtl/status_led_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_ctrl_pkg
// Shared types and helpers for the status LED controller.
//   led_mode_e : per-channel LED mode encoding (2 bits per channel)
//   cnt_width  : bit width needed to hold the values 0..max_val (minimum 1)
// -----------------------------------------------------------------------------
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_ACT   = 2'd3
  } led_mode_e;

  // Width of a counter that must represent 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 32'd1);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/status_led_ctrl_stretch.sv
// -----------------------------------------------------------------------------
// led_stretch
// One LED channel: retriggerable activity stretch counter, mode mux and the
// registered (optionally inverted) LED drive.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   tick_i        : shared prescaler tick strobe
//   blink_i       : next-state blink phase, so BLINK LEDs switch together
//                   with the registered blink output
//   event_i       : activity pulse, level-sampled every cycle
//   mode_i        : channel mode (led_mode_e)
//   led_o         : registered LED pin drive
// -----------------------------------------------------------------------------
module led_stretch
  import led_ctrl_pkg::*;
#(
  parameter int unsigned STRETCH_TICKS = 50,
  parameter logic        LED_INV       = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       blink_i,
  input  logic       event_i,
  input  logic [1:0] mode_i,
  output logic       led_o
);

  localparam int unsigned   SW       = cnt_width(STRETCH_TICKS);
  localparam logic [SW-1:0] SCNT_MAX = SW'(STRETCH_TICKS);
  localparam logic [SW-1:0] SCNT_ONE = SW'(1'b1);
  localparam logic [SW-1:0] SCNT_ZERO = {SW{1'b0}};

  logic [SW-1:0] scnt_q, scnt_d;
  logic          led_q, led_d;
  logic          logical_s;
  led_mode_e     mode_s;

  assign mode_s = led_mode_e'(mode_i);

  // Stretch counter next state and mode mux; ACTIVITY looks at the updated count.
  always_comb begin
    scnt_d    = scnt_q;
    logical_s = 1'b0;
    // A fresh event always reloads, even when a tick would have decremented.
    if (event_i) begin
      scnt_d = SCNT_MAX;
    end else if (tick_i && (scnt_q != SCNT_ZERO)) begin
      scnt_d = scnt_q - SCNT_ONE;
    end else begin
      scnt_d = scnt_q;
    end
    case (mode_s)
      LED_OFF:   logical_s = 1'b0;
      LED_ON:    logical_s = 1'b1;
      LED_BLINK: logical_s = blink_i;
      LED_ACT:   logical_s = (scnt_d != SCNT_ZERO);
      default:   logical_s = 1'b0;
    endcase
    led_d = logical_s ^ LED_INV;
  end

  // Stretch counter and LED output register; reset drives the off level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scnt_q <= SCNT_ZERO;
      led_q  <= LED_INV;
    end else begin
      scnt_q <= scnt_d;
      led_q  <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/status_led_ctrl.sv
// -----------------------------------------------------------------------------
// status_led_ctrl
// Board status block: N_CH LED channels (OFF/ON/BLINK/ACTIVITY), a shared tick
// prescaler, a shared blink phase and a delayed reset-release strobe.
//   CLK_i      : system clock
//   aresetn    : asynchronous active-low reset
//   mode_i     : per-channel mode, channel k in bits [2k+1:2k]
//   event_i    : per-channel activity pulses
//   led_o      : registered LED drive, per-channel polarity from LED_INV
//   blink_o    : shared blink phase
//   rst_done_o : sticky high RST_CYCLES edges after reset release
//   tick_o     : one-cycle prescaler tick strobe
// -----------------------------------------------------------------------------
module status_led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned     N_CH          = 4,
  parameter int unsigned     TICK_DIV      = 100000,
  parameter int unsigned     BLINK_HALF    = 500,
  parameter int unsigned     STRETCH_TICKS = 50,
  parameter int unsigned     RST_CYCLES    = 256,
  parameter logic [N_CH-1:0] LED_INV       = {N_CH{1'b0}}
) (
  input  logic              CLK_i,
  input  logic              aresetn,
  input  logic [2*N_CH-1:0] mode_i,
  input  logic [N_CH-1:0]   event_i,
  output logic [N_CH-1:0]   led_o,
  output logic              blink_o,
  output logic              rst_done_o,
  output logic              tick_o
);

  localparam int unsigned   TW         = cnt_width(TICK_DIV);
  localparam int unsigned   BW         = cnt_width(BLINK_HALF);
  localparam int unsigned   RW         = cnt_width(RST_CYCLES);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 32'd1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 32'd1);
  localparam logic [RW-1:0] RST_FULL   = RW'(RST_CYCLES);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic          rst_done_q, rst_done_d;

  // Prescaler, blink phase and reset-release next-state logic.
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    tick_d      = 1'b0;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    rst_cnt_d   = rst_cnt_q;
    rst_done_d  = rst_done_q;

    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = {TW{1'b0}};
      tick_d     = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1'b1);
      tick_d     = 1'b0;
    end

    // The blink phase flips on the same edge the half-period counter wraps.
    if (tick_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = {BW{1'b0}};
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1'b1);
        blink_d     = blink_q;
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
    end

    // Saturating release counter; done rises on the edge the count arrives.
    if (rst_cnt_q != RST_FULL) begin
      rst_cnt_d = rst_cnt_q + RW'(1'b1);
    end else begin
      rst_cnt_d = rst_cnt_q;
    end
    rst_done_d = rst_done_q | (rst_cnt_d == RST_FULL);
  end

  // Shared timing state registers.
  always_ff @(posedge CLK_i or negedge aresetn) begin
    if (!aresetn) begin
      tick_cnt_q  <= {TW{1'b0}};
      tick_q      <= 1'b0;
      blink_cnt_q <= {BW{1'b0}};
      blink_q     <= 1'b0;
      rst_cnt_q   <= {RW{1'b0}};
      rst_done_q  <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      rst_cnt_q   <= rst_cnt_d;
      rst_done_q  <= rst_done_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    led_stretch #(
      .STRETCH_TICKS (STRETCH_TICKS),
      .LED_INV       (LED_INV[k])
    ) u_ch (
      .clk_i   (CLK_i),
      .rst_ni  (aresetn),
      .tick_i  (tick_q),
      .blink_i (blink_d),
      .event_i (event_i[k]),
      .mode_i  (mode_i[2*k+1:2*k]),
      .led_o   (led_o[k])
    );
  end

  assign blink_o    = blink_q;
  assign rst_done_o = rst_done_q;
  assign tick_o     = tick_q;

endmodule

// File: tb/tb_status_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_status_led_ctrl
// Directed bench for status_led_ctrl with N_CH=4, TICK_DIV=4, BLINK_HALF=3,
// STRETCH_TICKS=2, RST_CYCLES=5, LED_INV=4'b1000. Inputs change on the falling
// edge, outputs are sampled on the falling edge; e counts rising edges since
// the latest reset release.
// -----------------------------------------------------------------------------
module tb_status_led_ctrl;

  logic       clk;
  logic       aresetn;
  logic [7:0] mode;
  logic [3:0] ev;
  logic [3:0] led;
  logic       blink;
  logic       rst_done;
  logic       tick;

  int tests_run = 0;
  int fail_cnt  = 0;
  int e         = 0;

  status_led_ctrl #(
    .N_CH          (4),
    .TICK_DIV      (4),
    .BLINK_HALF    (3),
    .STRETCH_TICKS (2),
    .RST_CYCLES    (5),
    .LED_INV       (4'b1000)
  ) dut (
    .CLK_i      (clk),
    .aresetn    (aresetn),
    .mode_i     (mode),
    .event_i    (ev),
    .led_o      (led),
    .blink_o    (blink),
    .rst_done_o (rst_done),
    .tick_o     (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, expected finish before 50000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    e++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_led"},   32'(led),      32'h8);
    chk({tag, "_blink"}, 32'(blink),    32'h0);
    chk({tag, "_done"},  32'(rst_done), 32'h0);
    chk({tag, "_tick"},  32'(tick),     32'h0);
  endtask

  initial begin
    logic bexp;
    aresetn = 1'b1;
    mode    = 8'b0000_0010;   // ch0 BLINK, others OFF
    ev      = 4'b0000;
    #1 aresetn = 1'b0;

    // Reset state
    @(negedge clk);
    chk_reset_vals("rst");
    cyc();
    chk_reset_vals("rst_hold");
    aresetn = 1'b1;
    e = 0;

    // Tick every 4 edges, blink toggles at edges 13, 25, 37; done from edge 5
    for (int i = 1; i <= 40; i++) begin
      cyc();
      bexp = (((e - 1) / 12) % 2) == 1;
      chk("tick",  32'(tick),     32'((e % 4) == 0));
      chk("blink", 32'(blink),    32'(bexp));
      chk("done",  32'(rst_done), 32'(e >= 5));
      chk("led",   32'(led),      32'({3'b100, bexp}));
    end

    // Single activity pulse just after the tick at edge 40
    mode = 8'b0000_1110;       // ch1 ACTIVITY
    cyc();                     // e=41
    chk("act_pre", 32'(led[1]), 32'h0);
    ev = 4'b0010;
    cyc();                     // e=42, reload to 2
    chk("act_on", 32'(led[1]), 32'h1);
    ev = 4'b0000;
    for (int i = 43; i <= 52; i++) begin
      cyc();                   // decrements at edges 45 and 49
      chk("act_single", 32'(led[1]), 32'(e <= 48));
    end

    // Event coincident with tick (edge 53), retrigger 5 cycles later (edge 58)
    chk("tick_at52", 32'(tick), 32'h1);
    ev = 4'b0010;
    cyc();                     // e=53
    chk("retrig1", 32'(led[1]), 32'h1);
    ev = 4'b0000;
    for (int i = 54; i <= 57; i++) begin
      cyc();
      chk("retrig_hold1", 32'(led[1]), 32'h1);
    end
    ev = 4'b0010;
    cyc();                     // e=58
    chk("retrig2", 32'(led[1]), 32'h1);
    ev = 4'b0000;
    for (int i = 59; i <= 66; i++) begin
      cyc();                   // decrements at edges 61 and 65
      chk("retrig_hold2", 32'(led[1]), 32'(e <= 64));
    end

    // Modes and inversion
    chk("ch3_off_pre", 32'(led[3]), 32'h1);
    mode = 8'b0100_1110;       // ch3 ON
    cyc();                     // e=67
    chk("ch3_on", 32'(led[3]), 32'h0);
    mode = 8'b0000_1110;
    cyc();                     // e=68
    chk("ch3_off", 32'(led[3]), 32'h1);
    mode = 8'b0001_1110;       // ch2 ON
    cyc();                     // e=69
    chk("ch2_on", 32'(led[2]), 32'h1);
    mode = 8'b0000_1110;
    ev   = 4'b0010;            // start a stretch for the mid-run reset
    cyc();                     // e=70
    chk("ch2_off", 32'(led[2]), 32'h0);
    chk("pre_rst_led",   32'(led),   32'hB);
    chk("pre_rst_blink", 32'(blink), 32'h1);
    chk("pre_rst_done",  32'(rst_done), 32'h1);

    // Mid-run reset during blink-high with an active stretch
    ev = 4'b0000;
    aresetn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    cyc();
    chk_reset_vals("midrst_hold");
    aresetn = 1'b1;
    e = 0;
    for (int i = 1; i <= 14; i++) begin
      cyc();
      chk("re_tick",  32'(tick),     32'((e % 4) == 0));
      chk("re_blink", 32'(blink),    32'(e >= 13));
      chk("re_done",  32'(rst_done), 32'(e >= 5));
      chk("re_led",   32'(led),      32'({3'b100, (e >= 13)}));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/status_led_ctrl.md
Name: status_led_ctrl

Overview:
Parametrised board-status block that drives N_CH LEDs and generates a delayed reset-release strobe for downstream logic such as the Ethernet block design's AXI reset. It replaces ad-hoc per-clock blink counters and reset counters in top-levels. Each channel is run-time selectable between OFF, ON, synchronised BLINK and ACTIVITY, where ACTIVITY is a retriggerable pulse stretch of an event input. All timing derives from one shared tick prescaler. The block sits in the top-level beside the block design and drives LED pins directly.

Parameters:
N_CH, 4, number of LED channels (1..32)
TICK_DIV, 100000, clock cycles per tick (>=1; 1 = tick every cycle)
BLINK_HALF, 500, ticks per blink half-period (>=1)
STRETCH_TICKS, 50, ACTIVITY on-time in ticks (>=1)
RST_CYCLES, 256, clock cycles from reset deassertion to rst_done_o (>=1)
LED_INV, 0, N_CH-bit mask; bit=1 inverts that channel's output (active-low LED)

Ports:
CLK_i  in  1  system clock
aresetn  in  1  asynchronous active-low reset
mode_i  in  2*N_CH  per-channel mode; channel k in bits [2k+1:2k]
event_i  in  N_CH  per-channel activity pulse, synchronous to CLK_i, level-sampled every cycle
led_o  out  N_CH  registered LED drive, polarity per LED_INV
blink_o  out  1  shared blink phase, for external heartbeat use
rst_done_o  out  1  sticky high once RST_CYCLES cycles have elapsed after reset
tick_o  out  1  one-cycle prescaler tick strobe

Behaviour:
- Reset, asynchronous and active-low: all counters = 0; blink_o = 0; rst_done_o = 0; tick_o = 0; every stretch counter = 0; led_o[k] = LED_INV[k], which is the logical-off level.
- Prescaler: tick_cnt counts 0..TICK_DIV-1 and wraps. tick_o is registered and is 1 in the cycle after tick_cnt == TICK_DIV-1. For TICK_DIV=1, tick_o is constantly 1 after the first clock edge.
- Blink: blink_cnt advances only on tick_o and wraps at BLINK_HALF-1. blink_o toggles on the same edge as that wrap. Full blink period = 2*BLINK_HALF*TICK_DIV cycles. All BLINK channels are phase-locked to blink_o.
- Stretch, per channel k: scnt[k] has width clog2(STRETCH_TICKS+1).
  - event_i[k] = 1: scnt[k] <= STRETCH_TICKS. Reload wins over a simultaneous tick decrement.
  - Otherwise, if tick_o is 1 and scnt[k] != 0, scnt[k] decrements.
  - Stretch counters run in every mode, so switching to ACTIVITY shows any in-flight stretch immediately.
  - A single event gives an on-time between (STRETCH_TICKS-1)*TICK_DIV+1 and STRETCH_TICKS*TICK_DIV+1 cycles, depending on its tick alignment.
- Logical LED, from mode_i[k]:
  - 0 OFF: 0
  - 1 ON: 1
  - 2 BLINK: blink_o
  - 3 ACTIVITY: scnt[k] != 0, computed from the updated value
- led_o[k] = register(logical ^ LED_INV[k]).
- Latency: a mode_i or event_i change at edge t appears on led_o at edge t+1. No combinational input-to-output path.
- Reset release: rst_cnt saturates at RST_CYCLES. rst_done_o goes to 1 on the edge where rst_cnt reaches RST_CYCLES, i.e. the RST_CYCLES-th edge after aresetn deasserts, and stays 1 until the next reset.
- Reset mid-operation: everything returns to reset values immediately. rst_done_o drops asynchronously and then repeats the full RST_CYCLES delay.
- Counters never overflow. All comparisons use widths from clog2(param+1).

Decomposition:
- Package led_ctrl_pkg:
  - enum led_mode_e {LED_OFF=2'd0, LED_ON=2'd1, LED_BLINK=2'd2, LED_ACT=2'd3}
  - function for clog2-based width helpers
- Sub-module led_stretch: a single-channel retriggerable stretch counter, plus mode mux and output register. It is instantiated N_CH times by a generate loop.
- The top keeps the prescaler, blink phase and reset-release counter.

Test Plan:
Bench parameters for all scenarios: N_CH=4, TICK_DIV=4, BLINK_HALF=3, STRETCH_TICKS=2, RST_CYCLES=5, LED_INV=4'b1000.
- Reset check: hold aresetn=0, then release. Required: led_o=4'b1000, blink_o=0, rst_done_o=0. rst_done_o rises exactly on the 5th edge after release and stays 1.
- Tick and blink: release reset with mode ch0=BLINK. Required: tick_o pulses every 4 cycles. blink_o and led_o[0] toggle every 12 cycles, giving a 24-cycle period.
- Activity single pulse: ch1=ACTIVITY; pulse event_i[1] for one cycle just after a tick. Required: led_o[1]=1 from the next edge, for 5 to 9 cycles, then 0.
- Retrigger and simultaneity: pulse event_i[1] on the same cycle as tick_o, again 5 cycles later. Required: the counter reloads to 2 both times (no decrement) and the LED stays on continuously until 2 ticks after the last event.
- Modes and inversion: ch3 ON, then OFF. Required: led_o[3] is 0 then 1 (inverted). ch2 ON, then OFF gives 1 then 0, each one cycle after the mode_i change.
- Mid-run reset: assert aresetn for 1 cycle during a blink-high phase with an active stretch. Required: outputs are at reset values immediately, blink restarts from phase 0, and rst_done_o re-rises 5 edges after release.
